// File: rtl/shift_unit_pkg.sv
// Shared op codes and helpers for the pipelined barrel shifter.
// Op codes above OP_ROR are illegal and pass data through unchanged.
package shift_unit_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Request/response bundle of the shifter: valid/ready request side with
// operand, shift amount, op and tag; valid/ready result side.
interface shift_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_illegal;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_illegal
  );
endinterface

// File: rtl/shift_unit_layer.sv
// One combinational mux layer: shifts or rotates by DIST when en is set.
// Illegal op codes leave the data untouched.
module shift_unit_layer
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (en) begin
      case (op)
        OP_SLL:  data_out = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
        OP_SRL:  data_out = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
        // The MSB survives every SRA layer, so it stays the correct sign.
        OP_SRA:  data_out = {{DIST{data_in[WIDTH-1]}}, data_in[WIDTH-1:DIST]};
        OP_ROL:  data_out = {data_in[WIDTH-DIST-1:0], data_in[WIDTH-1:WIDTH-DIST]};
        OP_ROR:  data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
        default: data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Elastic pipelined barrel shifter: one log2 layer per stage (PIPELINE=1)
// or all layers combinational into a single output register (PIPELINE=0).
module shift_unit_pipe
  import shift_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PIPELINE = 1,
  parameter int TAG_W    = 4
) (
  input  logic          clock,
  input  logic          reset,
  shift_unit_pipe_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int NS      = (PIPELINE != 0) ? SHAMT_W : 1;

  logic               vld_q   [NS];
  logic               vld_d   [NS];
  logic [WIDTH-1:0]   data_q  [NS];
  logic [WIDTH-1:0]   data_d  [NS];
  logic [SHAMT_W-1:0] shamt_q [NS];
  logic [SHAMT_W-1:0] shamt_d [NS];
  logic [2:0]         op_q    [NS];
  logic [2:0]         op_d    [NS];
  logic [TAG_W-1:0]   tag_q   [NS];
  logic [TAG_W-1:0]   tag_d   [NS];
  logic               ill_q   [NS];
  logic               ill_d   [NS];

  // chain_* is what each stage would load: the request for stage 0,
  // otherwise the contents of the stage before it.
  logic               chain_vld   [NS];
  logic [SHAMT_W-1:0] chain_shamt [NS];
  logic [2:0]         chain_op    [NS];
  logic [TAG_W-1:0]   chain_tag   [NS];
  logic               chain_ill   [NS];
  logic [WIDTH-1:0]   stage_in_dat [NS];
  logic               ld [NS];

  always_comb begin
    chain_vld[0]   = bus.in_valid;
    chain_shamt[0] = bus.in_shamt;
    chain_op[0]    = bus.in_op;
    chain_tag[0]   = bus.in_tag;
    chain_ill[0]   = !is_legal_op(bus.in_op);
    for (int k = 1; k < NS; k++) begin
      chain_vld[k]   = vld_q[k-1];
      chain_shamt[k] = shamt_q[k-1];
      chain_op[k]    = op_q[k-1];
      chain_tag[k]   = tag_q[k-1];
      chain_ill[k]   = ill_q[k-1];
    end
  end

  // Load enables ripple back from the consumer: a stage loads when empty
  // or when its successor frees it in the same cycle.
  always_comb begin
    ld[NS-1] = !vld_q[NS-1] || bus.out_ready;
    for (int k = NS - 2; k >= 0; k--) begin
      ld[k] = !vld_q[k] || ld[k+1];
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_layer
    logic [WIDTH-1:0] l_in;
    logic [WIDTH-1:0] l_out;
    logic             l_en;
    logic [2:0]       l_op;

    if (PIPELINE != 0) begin : g_pipe
      if (k == 0) begin : g_first
        assign l_in = bus.in_data;
      end else begin : g_next
        assign l_in = data_q[k-1];
      end
      assign l_en = chain_shamt[k][k];
      assign l_op = chain_op[k];
    end else begin : g_comb
      if (k == 0) begin : g_first
        assign l_in = bus.in_data;
      end else begin : g_next
        assign l_in = g_layer[k-1].l_out;
      end
      assign l_en = chain_shamt[0][k];
      assign l_op = chain_op[0];
    end

    shift_unit_layer #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_layer (
      .data_in  (l_in),
      .en       (l_en),
      .op       (l_op),
      .data_out (l_out)
    );
  end

  if (PIPELINE != 0) begin : g_stg_pipe
    for (genvar k = 0; k < NS; k++) begin : g_s
      assign stage_in_dat[k] = g_layer[k].l_out;
    end
  end else begin : g_stg_comb
    assign stage_in_dat[0] = g_layer[SHAMT_W-1].l_out;
  end

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      vld_d[k]   = vld_q[k];
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      op_d[k]    = op_q[k];
      tag_d[k]   = tag_q[k];
      ill_d[k]   = ill_q[k];
      if (ld[k]) begin
        vld_d[k]   = chain_vld[k];
        data_d[k]  = stage_in_dat[k];
        shamt_d[k] = chain_shamt[k];
        op_d[k]    = chain_op[k];
        tag_d[k]   = chain_tag[k];
        ill_d[k]   = chain_ill[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k]   <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
        tag_q[k]   <= '0;
        ill_q[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k]   <= vld_d[k];
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        op_q[k]    <= op_d[k];
        tag_q[k]   <= tag_d[k];
        ill_q[k]   <= ill_d[k];
      end
    end
  end

  assign bus.in_ready    = ld[0];
  assign bus.out_valid   = vld_q[NS-1];
  assign bus.out_data    = data_q[NS-1];
  assign bus.out_tag     = tag_q[NS-1];
  assign bus.out_illegal = ill_q[NS-1];

endmodule
